// File: rtl/exp_unit_arbiter.sv
// rtl/exp_unit_arbiter.sv - round-robin, credit-controlled sharing of one fixed-latency FP32 exp unit
module exp_unit_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_fp32,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 exp_in_valid,
    output logic [31:0]          exp_in_fp32,
    input  logic                 exp_out_valid,
    input  logic [31:0]          exp_out_fp32,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_fp32,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic                 err_orphan
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RES_W = ID_W + 32;

    // Credits: operands issued but whose result has not yet been handed to the consumer.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             err_q, err_d;

    logic [ID_W-1:0]  tag_mem_q [DEPTH];
    logic [ID_W-1:0]  tag_mem_d [DEPTH];
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;

    logic [RES_W-1:0] res_mem_q [DEPTH];
    logic [RES_W-1:0] res_mem_d [DEPTH];
    logic [PTR_W-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    logic             can_issue;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             rsp_hs;
    logic             tag_push, tag_pop, res_push, res_pop;
    logic [RES_W-1:0] res_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue gating looks only at the registered credit count, so rsp_ready never reaches req_ready.
    assign can_issue = (cnt_q < CNT_W'(DEPTH));

    // Round-robin pick: first valid requester at or above the pointer, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_valid && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                end
            end
        end
    end

    // Drive the grant vector and the exp unit input; operand bus is zero when nothing issues.
    always_comb begin
        req_ready    = '0;
        exp_in_fp32  = '0;
        exp_in_valid = grant_valid;
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
            exp_in_fp32         = req_fp32[32*grant_id +: 32];
        end
    end

    assign res_head  = res_mem_q[res_rd_q];
    assign rsp_valid = (res_cnt_q != '0);
    assign rsp_id    = rsp_valid ? res_head[32 +: ID_W] : '0;
    assign rsp_fp32  = rsp_valid ? res_head[31:0] : '0;
    assign busy      = (cnt_q != '0);
    assign err_orphan = err_q;

    assign rsp_hs   = rsp_valid & rsp_ready;
    assign tag_push = grant_valid;
    assign tag_pop  = exp_out_valid && (tag_cnt_q != '0);
    assign res_push = tag_pop;
    assign res_pop  = rsp_hs;

    // Next state for credits, pointer and the sticky orphan flag.
    always_comb begin
        cnt_d = cnt_q;
        case ({grant_valid, rsp_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        err_d = err_q | (exp_out_valid && (tag_cnt_q == '0));
    end

    // Tag FIFO next state: granted ID in at issue, oldest ID out when its result returns.
    always_comb begin
        tag_mem_d = tag_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        if (tag_push) begin
            tag_mem_d[tag_wr_q] = grant_id;
            tag_wr_d            = ptr_inc(tag_wr_q);
        end
        if (tag_pop) begin
            tag_rd_d = ptr_inc(tag_rd_q);
        end
        if (tag_push && !tag_pop) begin
            tag_cnt_d = tag_cnt_q + CNT_W'(1);
        end else if (!tag_push && tag_pop) begin
            tag_cnt_d = tag_cnt_q - CNT_W'(1);
        end
    end

    // Result FIFO next state: tagged result in from the exp unit, out on response handshake.
    always_comb begin
        res_mem_d = res_mem_q;
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;
        res_cnt_d = res_cnt_q;
        if (res_push) begin
            res_mem_d[res_wr_q] = {tag_mem_q[tag_rd_q], exp_out_fp32};
            res_wr_d            = ptr_inc(res_wr_q);
        end
        if (res_pop) begin
            res_rd_d = ptr_inc(res_rd_q);
        end
        if (res_push && !res_pop) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end else if (!res_push && res_pop) begin
            res_cnt_d = res_cnt_q - CNT_W'(1);
        end
    end

    // Control state registers; reset discards anything in flight or buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // FIFO storage; contents are qualified by the occupancy counters so need no reset.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
        res_mem_q <= res_mem_d;
    end

    // Credits must keep both FIFOs from ever being pushed while full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(tag_push && !tag_pop && tag_cnt_q == CNT_W'(DEPTH)));
            assert (!(res_push && !res_pop && res_cnt_q == CNT_W'(DEPTH)));
        end
    end

endmodule

// File: tb/tb_exp_unit_arbiter.sv
// tb/tb_exp_unit_arbiter.sv - testbench for exp_unit_arbiter with a 3-cycle sign-flip exp stub
module tb_exp_unit_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_fp32;
    logic [3:0]   req_ready;
    logic         exp_in_valid;
    logic [31:0]  exp_in_fp32;
    logic         exp_out_valid;
    logic [31:0]  exp_out_fp32;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_fp32;
    logic         rsp_ready;
    logic         busy;
    logic         err_orphan;

    logic [31:0]  op [4];
    logic         orphan_pulse;
    logic [2:0]   sv;
    logic [31:0]  sd [3];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] fp;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rr;
        logic [1:0] ptr;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    assign req_fp32 = {op[3], op[2], op[1], op[0]};

    exp_unit_arbiter #(.NUM_REQ(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_fp32(req_fp32), .req_ready(req_ready),
        .exp_in_valid(exp_in_valid), .exp_in_fp32(exp_in_fp32),
        .exp_out_valid(exp_out_valid), .exp_out_fp32(exp_out_fp32),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_fp32(rsp_fp32), .rsp_ready(rsp_ready),
        .busy(busy), .err_orphan(err_orphan)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sv <= '0;
        end else begin
            sv    <= {sv[1:0], exp_in_valid};
            sd[0] <= exp_in_fp32 ^ 32'h8000_0000;
            sd[1] <= sd[0];
            sd[2] <= sd[1];
        end
    end
    assign exp_out_valid = sv[2] | orphan_pulse;
    assign exp_out_fp32  = sd[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    logic        hold_prev = 1'b0;
    logic [1:0]  prev_id;
    logic [31:0] prev_fp;

    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                check("rsp_hold_id", 64'(rsp_id), 64'(prev_id));
                check("rsp_hold_fp", 64'(rsp_fp32), 64'(prev_fp));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d fp %0h expected none", rsp_id, rsp_fp32);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_fp32", 64'(rsp_fp32), 64'(e.fp));
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_id   = rsp_id;
            prev_fp   = rsp_fp32;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        orphan_pulse = 1'b0;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic apply(input string name, input logic [3:0] rv, input logic [3:0] rr);
        int   g;
        rsp_t e;
        g = -1;
        req_valid = rv;
        #1;
        for (int i = 0; i < 4; i++) if (rr[i]) g = i;
        check({name, "_req_ready"}, 64'(req_ready), 64'(rr));
        check({name, "_in_valid"}, 64'(exp_in_valid), 64'(rr != 4'b0));
        check({name, "_in_fp32"}, 64'(exp_in_fp32), (g >= 0) ? 64'(op[g]) : 64'd0);
        if (g >= 0) begin
            e.id = 2'(g);
            e.fp = op[g] ^ 32'h8000_0000;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check({name, "_drain_busy"}, 64'(busy), 64'd0);
        check({name, "_drain_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0001, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0010, 2'd2};
        tbl[3]  = '{4'b0001, 4'b0001, 2'd1};
        tbl[4]  = '{4'b1000, 4'b1000, 2'd0};
        tbl[5]  = '{4'b0110, 4'b0010, 2'd2};
        tbl[6]  = '{4'b0110, 4'b0100, 2'd3};
        tbl[7]  = '{4'b0011, 4'b0001, 2'd1};
        tbl[8]  = '{4'b1100, 4'b0100, 2'd3};
        tbl[9]  = '{4'b0100, 4'b0100, 2'd3};
        tbl[10] = '{4'b0000, 4'b0000, 2'd3};
        tbl[11] = '{4'b1111, 4'b1000, 2'd0};

        op[0] = 32'h3F80_0000;
        op[1] = 32'h4000_0000;
        op[2] = 32'h4040_0000;
        op[3] = 32'hC080_0000;

        // Reset state
        do_reset();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_in_valid", 64'(exp_in_valid), 64'd0);
        check("rst_in_fp32", 64'(exp_in_fp32), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_fp32", 64'(rsp_fp32), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_orphan), 64'd0);
        check("rst_ptr", 64'(dut.ptr_q), 64'd0);
        check("rst_cnt", 64'(dut.cnt_q), 64'd0);

        // Single op latency
        rsp_ready = 1'b1;
        apply("single", 4'b0001, 4'b0001);
        step();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("single_rsp_valid_t%0d", k), 64'(rsp_valid), 64'(k == 4));
            check($sformatf("single_busy_t%0d", k), 64'(busy), 64'd1);
            if (k < 4) step();
        end
        check("single_rsp_id", 64'(rsp_id), 64'd0);
        check("single_rsp_fp32", 64'(rsp_fp32), 64'hBF80_0000);
        step();
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_rsp_valid_after", 64'(rsp_valid), 64'd0);

        // Arbitration vector table
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].rv, tbl[i].rr);
            step();
            check($sformatf("tbl%0d_ptr", i), 64'(dut.ptr_q), 64'(tbl[i].ptr));
        end
        drain("tbl");

        // All four continuously valid
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            apply($sformatf("rr%0d", k), 4'hF, 4'(1 << (k % 4)));
            step();
        end
        drain("rr");

        // Backpressure: credits run out after 8 issues
        do_reset();
        for (int k = 0; k < 14; k++) begin
            op[0] = 32'h3F80_0000 + 32'(k);
            apply($sformatf("bp%0d", k), 4'b0001, (k < 8) ? 4'b0001 : 4'b0000);
            step();
        end
        check("bp_cnt_full", 64'(dut.cnt_q), 64'd8);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        op[0] = 32'h3F80_0100;
        apply("bp_first_hs", 4'b0001, 4'b0000);
        step();
        op[0] = 32'h3F80_0200;
        apply("bp_resume", 4'b0001, 4'b0001);
        step();
        drain("bp");

        // Issue and response handshake in the same cycle at cnt = 7
        do_reset();
        for (int k = 0; k < 7; k++) begin
            op[0] = 32'h4000_0000 + 32'(k);
            apply($sformatf("c7_%0d", k), 4'b0001, 4'b0001);
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) step();
        check("c7_cnt_before", 64'(dut.cnt_q), 64'd7);
        rsp_ready = 1'b1;
        op[0] = 32'h4000_0100;
        apply("c7_both", 4'b0001, 4'b0001);
        step();
        req_valid = '0;
        check("c7_cnt_after", 64'(dut.cnt_q), 64'd7);
        drain("c7");

        // Orphan result
        do_reset();
        check("orph_err_init", 64'(err_orphan), 64'd0);
        orphan_pulse = 1'b1;
        step();
        orphan_pulse = 1'b0;
        check("orph_err_set", 64'(err_orphan), 64'd1);
        check("orph_rsp_valid", 64'(rsp_valid), 64'd0);
        check("orph_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) step();
        check("orph_err_sticky", 64'(err_orphan), 64'd1);
        check("orph_rsp_valid_later", 64'(rsp_valid), 64'd0);
        do_reset();
        check("orph_err_cleared", 64'(err_orphan), 64'd0);

        // Reset mid-burst with three in flight and two buffered
        do_reset();
        for (int k = 0; k < 5; k++) begin
            op[1] = 32'h3F00_0000 + 32'(k);
            apply($sformatf("mid%0d", k), 4'b0010, 4'b0010);
            step();
        end
        req_valid = '0;
        check("mid_cnt", 64'(dut.cnt_q), 64'd5);
        check("mid_buffered", 64'(dut.res_cnt_q), 64'd2);
        do_reset();
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ptr", 64'(dut.ptr_q), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("mid_quiet%0d", k), 64'(rsp_valid), 64'd0);
        end
        rsp_ready = 1'b1;
        op[2] = 32'h3FC0_0000;
        apply("mid_new", 4'b0100, 4'b0100);
        step();
        drain("mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
